// File: rtl/latch_bank_arbiter_if.sv
// Requester-side bundle for latch_bank_arbiter: write requests, bank clear/preset commands and their responses.
interface latch_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 3
);
   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic                  clr_req;
   logic                  pre_req;
   logic                  clr_done;
   logic                  pre_done;

   modport master (
      output req, addr, wdata, clr_req, pre_req,
      input  gnt, ack, clr_done, pre_done
   );

   modport slave (
      input  req, addr, wdata, clr_req, pre_req,
      output gnt, ack, clr_done, pre_done
   );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Write/clear/preset sequencer that owns every control pin of a shared gated-D latch bank.
// Define LATCH_ARB_FIXED_PRIO_EN for lowest-index-wins write arbitration instead of round-robin.
module latch_bank_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int GATE_CYC  = 1,
   parameter int PULSE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   latch_bank_arbiter_if.slave  bus,
   output logic [WIDTH-1:0]     lat_d,
   output logic [DEPTH-1:0]     lat_g,
   output logic                 lat_set_n,
   output logic                 lat_reset_n,
   output logic                 busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = $clog2(NREQ);
   localparam logic [3:0] GATE_LAST  = 4'(GATE_CYC - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CLR, PRE} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IW-1:0]     winner_q, winner_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WIDTH-1:0]  latD_q, latD_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [DEPTH-1:0]  latG_q, latG_d;
   logic              setN_q, setN_d;
   logic              resetN_q, resetN_d;
   logic              clrDone_q, clrDone_d;
   logic              preDone_q, preDone_d;
   logic              busy_q, busy_d;
   logic [IW-1:0]     arbIdx;
   logic              arbFound;
`ifndef LATCH_ARB_FIXED_PRIO_EN
   logic [IW-1:0]     rrPtr_q, rrPtr_d;
`endif

   // The search starts at the RR pointer (the slot after the last winner), or at 0 under fixed priority.
   always_comb begin
      int idx;
      idx      = 0;
      arbIdx   = '0;
      arbFound = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = int'(rrPtr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
`endif
         if (!arbFound && bus.req[idx]) begin
            arbFound = 1'b1;
            arbIdx   = IW'(idx);
         end
      end
   end

   // Commands are accepted only in IDLE and HOLD, so a pending write chains straight from HOLD into SETUP.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      addr_d   = addr_q;
      latD_d   = latD_q;
`ifndef LATCH_ARB_FIXED_PRIO_EN
      rrPtr_d  = rrPtr_q;
`endif
      case (state_q)
         SETUP: begin
            state_d = GATE;
            cnt_d   = '0;
         end
         GATE: begin
            if (cnt_q == GATE_LAST) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD: state_d = IDLE;
         CLR, PRE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q == IDLE || state_q == HOLD) begin
         if (bus.clr_req) begin
            state_d = CLR;
            cnt_d   = '0;
         end else if (bus.pre_req) begin
            state_d = PRE;
            cnt_d   = '0;
         end else if (arbFound) begin
            state_d  = SETUP;
            winner_d = arbIdx;
            addr_d   = bus.addr[int'(arbIdx)*AW +: AW];
            latD_d   = bus.wdata[int'(arbIdx)*WIDTH +: WIDTH];
`ifndef LATCH_ARB_FIXED_PRIO_EN
            rrPtr_d  = (arbIdx == IW'(NREQ - 1)) ? '0 : arbIdx + IW'(1);
`endif
         end
      end
   end

   // Outputs are decoded from the next state so every pin comes straight off a flop.
   always_comb begin
      logic [NREQ-1:0] winOh;
      winOh            = '0;
      winOh[winner_d]  = 1'b1;
      gnt_d     = (state_d == SETUP || state_d == GATE || state_d == HOLD) ? winOh : '0;
      ack_d     = (state_d == HOLD) ? winOh : '0;
      latG_d    = (state_d == GATE) ? (DEPTH'(1) << addr_d) : '0;
      resetN_d  = (state_d != CLR);
      setN_d    = (state_d != PRE);
      clrDone_d = (state_d == CLR) && (cnt_d == PULSE_LAST);
      preDone_d = (state_d == PRE) && (cnt_d == PULSE_LAST);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         winner_q  <= '0;
         addr_q    <= '0;
         latD_q    <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         latG_q    <= '0;
         setN_q    <= 1'b1;
         resetN_q  <= 1'b1;
         clrDone_q <= 1'b0;
         preDone_q <= 1'b0;
         busy_q    <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
         rrPtr_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         winner_q  <= winner_d;
         addr_q    <= addr_d;
         latD_q    <= latD_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         latG_q    <= latG_d;
         setN_q    <= setN_d;
         resetN_q  <= resetN_d;
         clrDone_q <= clrDone_d;
         preDone_q <= preDone_d;
         busy_q    <= busy_d;
`ifndef LATCH_ARB_FIXED_PRIO_EN
         rrPtr_q   <= rrPtr_d;
`endif
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.clr_done = clrDone_q;
   assign bus.pre_done = preDone_q;
   assign lat_d        = latD_q;
   assign lat_g        = latG_q;
   assign lat_set_n    = setN_q;
   assign lat_reset_n  = resetN_q;
   assign busy         = busy_q;

   // Driving set and reset low together would leave the latch cells in an undefined state.
   assert property (@(posedge clk) disable iff (!reset_n) (lat_set_n || lat_reset_n));
   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(lat_g));
   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bus.gnt));

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Randomized self-checking bench for latch_bank_arbiter against a transaction-timeline reference model.
module tb_latch_bank_arbiter;

   // DEPTH of 6 keeps addresses 6 and 7 representable but outside the bank.
   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int DEPTH     = 6;
   localparam int GATE_CYC  = 2;
   localparam int PULSE_CYC = 2;
   localparam int AW        = $clog2(DEPTH);
   localparam int OBSW      = 2*NREQ + DEPTH + WIDTH + 5;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] lat_d;
   logic [DEPTH-1:0] lat_g;
   logic             lat_set_n;
   logic             lat_reset_n;
   logic             busy;

   latch_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

   latch_bank_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .GATE_CYC(GATE_CYC), .PULSE_CYC(PULSE_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .lat_d(lat_d), .lat_g(lat_g), .lat_set_n(lat_set_n), .lat_reset_n(lat_reset_n), .busy(busy)
   );

   always #5 clk = ~clk;

   // Snapshot of every output in one word: {gnt, ack, lat_g, lat_d, busy, set_n, reset_n, clr_done, pre_done}.
   logic [OBSW-1:0] obs;
   assign obs = {bus.gnt, bus.ack, lat_g, lat_d, busy, lat_set_n, lat_reset_n, bus.clr_done, bus.pre_done};

   int               checks   = 0;
   int               errors   = 0;
   int               rrNext   = 0;
   logic [WIDTH-1:0] lastData = '0;
   logic [OBSW-1:0]  expObs;

   function automatic logic [OBSW-1:0] expIdle();
      return {{NREQ{1'b0}}, {NREQ{1'b0}}, {DEPTH{1'b0}}, lastData, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   endfunction

   // Phase p of a write: 0 = setup, 1..GATE_CYC = gate open, GATE_CYC+1 = hold with ack.
   function automatic logic [OBSW-1:0] expWrite(int w, int a, logic [WIDTH-1:0] d, int p);
      logic [NREQ-1:0]  oh;
      logic [NREQ-1:0]  ackOh;
      logic [DEPTH-1:0] g;
      oh    = '0;
      oh[w] = 1'b1;
      ackOh = (p == GATE_CYC + 1) ? oh : '0;
      g     = '0;
      if (p >= 1 && p <= GATE_CYC && a < DEPTH) g[a] = 1'b1;
      return {oh, ackOh, g, d, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   endfunction

   // Cycle k (1..PULSE_CYC) of a clear or preset pulse.
   function automatic logic [OBSW-1:0] expPulse(bit isClr, int k);
      bit last;
      last = (k == PULSE_CYC);
      return {{NREQ{1'b0}}, {NREQ{1'b0}}, {DEPTH{1'b0}}, lastData, 1'b1,
              isClr, !isClr, isClr && last, !isClr && last};
   endfunction

   function automatic int pickWinner(logic [NREQ-1:0] r);
`ifdef LATCH_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (r[(rrNext + k) % NREQ]) return (rrNext + k) % NREQ;
`endif
      return -1;
   endfunction

   task automatic test_reset();
      bus.req = '0; bus.addr = '0; bus.wdata = '0; bus.clr_req = 1'b0; bus.pre_req = 1'b0;
      reset_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         expObs = expIdle();
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL reset_state actual=%h required=%h", obs, expObs);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      expObs = expIdle();
      checks++;
      if (obs !== expObs) begin
         errors++;
         $display("[TB] FAIL idle_after_reset actual=%h required=%h", obs, expObs);
      end
   endtask

   task automatic test_back_to_back();
`ifdef LATCH_ARB_FIXED_PRIO_EN
      int seq[5] = '{0, 0, 0, 0, 0};
`else
      int seq[5] = '{0, 1, 2, 3, 0};
`endif
      logic [WIDTH-1:0] d;
      for (int i = 0; i < NREQ; i++) begin
         bus.addr[i*AW +: AW]        = AW'(i + 1);
         bus.wdata[i*WIDTH +: WIDTH] = WIDTH'(8'h30 + i);
      end
      bus.req = '1;
      for (int n = 0; n < 5; n++) begin
         d = WIDTH'(8'h30 + seq[n]);
         for (int p = 0; p < GATE_CYC + 2; p++) begin
            @(negedge clk);
            expObs = expWrite(seq[n], seq[n] + 1, d, p);
            checks++;
            if (obs !== expObs) begin
               errors++;
               $display("[TB] FAIL back_to_back n=%0d p=%0d actual=%h required=%h", n, p, obs, expObs);
            end
         end
         lastData = d;
         rrNext   = (seq[n] + 1) % NREQ;
      end
      bus.req = '0;
   endtask

   task automatic test_single_write();
      int w;
      bus.addr[0 +: AW]    = AW'(3);
      bus.wdata[0 +: WIDTH] = 8'hA5;
      bus.req = 4'b0001;
      w = pickWinner(bus.req);
      for (int p = 0; p < GATE_CYC + 2; p++) begin
         @(negedge clk);
         expObs = expWrite(w, 3, 8'hA5, p);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL single_write p=%0d actual=%h required=%h", p, obs, expObs);
         end
         if (p == 0) bus.req = '0;
      end
      lastData = 8'hA5;
      rrNext   = (w + 1) % NREQ;
      @(negedge clk);
      expObs = expIdle();
      checks++;
      if (obs !== expObs) begin
         errors++;
         $display("[TB] FAIL single_write_idle actual=%h required=%h", obs, expObs);
      end
   endtask

   task automatic test_clear_then_write();
      int w;
      bus.addr[1*AW +: AW]        = AW'(2);
      bus.wdata[1*WIDTH +: WIDTH] = 8'h5C;
      bus.clr_req = 1'b1;
      bus.req     = 4'b0010;
      for (int k = 1; k <= PULSE_CYC; k++) begin
         @(negedge clk);
         expObs = expPulse(1'b1, k);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL clear_pulse k=%0d actual=%h required=%h", k, obs, expObs);
         end
      end
      bus.clr_req = 1'b0;
      @(negedge clk);
      expObs = expIdle();
      checks++;
      if (obs !== expObs) begin
         errors++;
         $display("[TB] FAIL clear_idle actual=%h required=%h", obs, expObs);
      end
      w = pickWinner(bus.req);
      for (int p = 0; p < GATE_CYC + 2; p++) begin
         @(negedge clk);
         expObs = expWrite(w, 2, 8'h5C, p);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL write_after_clear p=%0d actual=%h required=%h", p, obs, expObs);
         end
         if (p == 0) bus.req = '0;
      end
      lastData = 8'h5C;
      rrNext   = (w + 1) % NREQ;
   endtask

   task automatic test_clr_pre();
      bus.clr_req = 1'b1;
      bus.pre_req = 1'b1;
      for (int phase = 0; phase < 2; phase++) begin
         for (int k = 1; k <= PULSE_CYC; k++) begin
            @(negedge clk);
            expObs = expPulse(phase == 0, k);
            checks++;
            if (obs !== expObs) begin
               errors++;
               $display("[TB] FAIL clr_pre phase=%0d k=%0d actual=%h required=%h", phase, k, obs, expObs);
            end
         end
         if (phase == 0) bus.clr_req = 1'b0;
         else            bus.pre_req = 1'b0;
         @(negedge clk);
         expObs = expIdle();
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL clr_pre_idle phase=%0d actual=%h required=%h", phase, obs, expObs);
         end
      end
   endtask

   task automatic test_out_of_range();
      int w;
      for (int a = DEPTH; a < (1 << AW); a++) begin
         bus.addr[0 +: AW]     = AW'(a);
         bus.wdata[0 +: WIDTH] = WIDTH'(8'h3C + a);
         bus.req = 4'b0001;
         w = pickWinner(bus.req);
         for (int p = 0; p < GATE_CYC + 2; p++) begin
            @(negedge clk);
            expObs = expWrite(w, a, WIDTH'(8'h3C + a), p);
            checks++;
            if (obs !== expObs) begin
               errors++;
               $display("[TB] FAIL out_of_range a=%0d p=%0d actual=%h required=%h", a, p, obs, expObs);
            end
            if (p == 0) bus.req = '0;
         end
         lastData = WIDTH'(8'h3C + a);
         rrNext   = (w + 1) % NREQ;
      end
   endtask

   task automatic test_random_writes(int iters);
      logic [NREQ-1:0]  r;
      logic [WIDTH-1:0] d;
      int               w;
      int               a;
      for (int it = 0; it < iters; it++) begin
         r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            bus.addr[i*AW +: AW]        = AW'($urandom_range(0, (1 << AW) - 1));
            bus.wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
         bus.req = r;
         if (r == '0) begin
            @(negedge clk);
            expObs = expIdle();
            checks++;
            if (obs !== expObs) begin
               errors++;
               $display("[TB] FAIL random_idle it=%0d actual=%h required=%h", it, obs, expObs);
            end
            continue;
         end
         w = pickWinner(r);
         a = int'(bus.addr[w*AW +: AW]);
         d = bus.wdata[w*WIDTH +: WIDTH];
         for (int p = 0; p < GATE_CYC + 2; p++) begin
            @(negedge clk);
            expObs = expWrite(w, a, d, p);
            checks++;
            if (obs !== expObs) begin
               errors++;
               $display("[TB] FAIL random_write it=%0d p=%0d actual=%h required=%h", it, p, obs, expObs);
            end
            if (p == 0 && $urandom_range(0, 3) == 0) bus.req = '0;
         end
         lastData = d;
         rrNext   = (w + 1) % NREQ;
      end
      bus.req = '0;
   endtask

   task automatic test_reset_mid_gate();
      int w;
      bus.addr[2*AW +: AW]        = AW'(1);
      bus.wdata[2*WIDTH +: WIDTH] = 8'h77;
      bus.req = 4'b0100;
      w = pickWinner(bus.req);
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         expObs = expWrite(w, 1, 8'h77, p);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL before_reset p=%0d actual=%h required=%h", p, obs, expObs);
         end
      end
      reset_n = 1'b0;
      bus.req = '0;
      #1;
      lastData = '0;
      rrNext   = 0;
      expObs   = expIdle();
      checks++;
      if (obs !== expObs) begin
         errors++;
         $display("[TB] FAIL reset_async actual=%h required=%h", obs, expObs);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL reset_hold actual=%h required=%h", obs, expObs);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         bus.addr[i*AW +: AW]        = AW'(i + 2);
         bus.wdata[i*WIDTH +: WIDTH] = WIDTH'(8'hC0 + i);
      end
      reset_n = 1'b1;
      bus.req = '1;
      w = pickWinner(bus.req);
      for (int p = 0; p < GATE_CYC + 2; p++) begin
         @(negedge clk);
         expObs = expWrite(0, 2, 8'hC0, p);
         checks++;
         if (obs !== expObs) begin
            errors++;
            $display("[TB] FAIL first_grant_after_reset p=%0d model=%0d actual=%h required=%h", p, w, obs, expObs);
         end
         if (p == 0) bus.req = '0;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_single_write();
      test_clear_then_write();
      test_clr_pre();
      test_out_of_range();
      test_random_writes(40);
      test_reset_mid_gate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
